clock_set_controller: RTL and testbench
=======================================

Name: clock_set_controller

Overview:
Sequencing controller for the clock chip's time-setting path. It turns debounced single-cycle button pulses into the run/set/stopwatch state code, a field-edit value, and one-cycle write enables. Those outputs drive the setting pass-through and the counter_60sec, counter_60min and counter_24h counters. It owns field selection, modulo up/down editing, commit/abort and the idle timeout.

Parameters:
TIMEOUT_CYCLES, 32'd500000000, idle cycles in any SET state before an automatic abort to RUN
CNT_W, 32, width of the idle-timeout counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
btn_mode  in  1  pulse: RUN->SET_HOUR; in any SET state, abort to RUN
btn_next  in  1  pulse: commit the current field, then advance to the next field
btn_up  in  1  pulse: increment the edit value
btn_down  in  1  pulse: decrement the edit value
btn_sw  in  1  pulse: toggle RUN<->STOPWATCH
cur_hour  in  6  live hour from counter_24h (0..23)
cur_min  in  6  live minute from counter_60min (0..59)
cur_sec  in  6  live second from counter_60sec (0..59)
state  out  2  00 RUN, 01 SET_HOUR/SET_MIN, 10 SET_SEC, 11 STOPWATCH
num  out  6  edit value presented to the counters
hour_enable  out  1  one-cycle load strobe for counter_24h
min_enable  out  1  one-cycle load strobe for counter_60min
sec_enable  out  1  one-cycle load strobe for counter_60sec
field_sel  out  2  00 none, 01 hour, 10 min, 11 sec (blink select for the display)
timeout_flag  out  1  one-cycle pulse when the idle timeout aborts a SET state

Behaviour:
- Reset (rst=0, asynchronous) sets the FSM to RUN and clears the edit register, timeout counter and all strobes. Output values at reset: state=00, num=0, all *_enable=0, field_sel=00, timeout_flag=0.
- FSM states are RUN, SET_HOUR, SET_MIN, SET_SEC, STOPWATCH. All outputs are registered.
- Button priority within one cycle: btn_mode > btn_next > btn_up/btn_down.
  - btn_up and btn_down together (with no higher-priority button) are both ignored.
  - btn_sw is honoured only in RUN and STOPWATCH; it is ignored in SET states.
- RUN:
  - btn_mode -> SET_HOUR; the edit register loads cur_hour at the same edge.
  - btn_sw -> STOPWATCH.
  - Other buttons are ignored.
- STOPWATCH: btn_sw or btn_mode -> RUN. No strobes are ever issued from STOPWATCH.
- SET_HOUR / SET_MIN / SET_SEC:
  - btn_up: edit = (edit == LIM-1) ? 0 : edit+1. LIM is 24 for hour and 60 for min/sec.
  - btn_down: edit = (edit == 0) ? LIM-1 : edit-1.
  - btn_next: at the press edge, the strobe for the current field is set high for exactly one cycle, with num holding the committed value during that cycle.
    - SET_HOUR -> SET_MIN (edit loads cur_min).
    - SET_MIN -> SET_SEC (edit loads cur_sec).
    - SET_SEC -> RUN.
  - btn_mode: abort to RUN. No strobe for the current field; fields committed earlier stay written.
- Edit value and num:
  - num follows the edit register in SET states.
  - num holds its last value in RUN and STOPWATCH.
  - An out-of-range cur_* value (hour >= 24, min/sec >= 60) is loaded as 0.
- Timeout:
  - The counter clears on any button pulse and on every state change.
  - In a SET state it increments each cycle.
  - At TIMEOUT_CYCLES-1 the FSM aborts to RUN with timeout_flag=1 for one cycle and no strobe.
  - A button pulse in the same cycle as the terminal count takes priority and the timeout is discarded.
- Strobe rules:
  - At most one *_enable is high in any cycle.
  - A strobe never coincides with a change of state into STOPWATCH.
- Reset asserted mid-set drops any pending strobe immediately; the counters keep their previous values.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> state=00, num=0, no strobes, field_sel=00.
- Full set: cur_hour=23. Press btn_mode, btn_up x1 -> num=0. btn_next -> hour_enable=1 for 1 cycle with num=0. With cur_min=5: btn_down x6 -> num=59. btn_next -> min_enable with num=59. btn_next -> sec_enable with num=cur_sec, state returns to 00.
- Abort: in SET_MIN with edit=30, press btn_mode -> state=00 and no min_enable; the earlier hour_enable commit is retained.
- Timeout: TIMEOUT_CYCLES=10, enter SET_SEC and stay idle -> after 10 cycles state=00, timeout_flag pulses once, sec_enable never asserts. Repeat with btn_up at cycle 9 -> no timeout.
- Simultaneous buttons: btn_up and btn_down in the same cycle -> edit unchanged. btn_mode and btn_next in the same cycle in SET_HOUR -> abort, no strobe. btn_sw in SET_SEC -> ignored.
- Stopwatch: btn_sw in RUN -> state=11. btn_up/btn_next -> no effect. btn_sw again -> state=00.

Source files
------------

// File: rtl/clock_set_controller.sv
// ---------------------------------------------------------------------------
// clock_set_controller : run/set/stopwatch sequencer for the clock time-setting path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module clock_set_controller #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500000000,
  parameter int          CNT_W          = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sw,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [1:0] state,
  output logic [5:0] num,
  output logic       hour_enable,
  output logic       min_enable,
  output logic       sec_enable,
  output logic [1:0] field_sel,
  output logic       timeout_flag
);

  typedef enum logic [2:0] {
    S_RUN  = 3'd0,
    S_HOUR = 3'd1,
    S_MIN  = 3'd2,
    S_SEC  = 3'd3,
    S_SW   = 3'd4
  } fsm_t;

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  fsm_t             fsm_q, fsm_d;
  logic [5:0]       edit_q, edit_d;
  logic [5:0]       num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;
  logic [1:0]       field_q, field_d;
  logic             hour_en_q, hour_en_d;
  logic             min_en_q, min_en_d;
  logic             sec_en_q, sec_en_d;
  logic             tflag_q, tflag_d;
  logic             any_btn;
  logic             commit;
  logic             set_d;
  logic             set_q;
  logic [5:0]       lim;

  function automatic logic [5:0] clamp(input logic [5:0] v, input logic [5:0] l);
    return (v >= l) ? 6'd0 : v;
  endfunction

  always_comb begin
    fsm_d     = fsm_q;
    edit_d    = edit_q;
    num_d     = num_q;
    hour_en_d = 1'b0;
    min_en_d  = 1'b0;
    sec_en_d  = 1'b0;
    tflag_d   = 1'b0;
    commit    = 1'b0;
    any_btn   = btn_mode | btn_next | btn_up | btn_down | btn_sw;
    lim       = (fsm_q == S_HOUR) ? 6'd24 : 6'd60;
    set_q     = (fsm_q == S_HOUR) || (fsm_q == S_MIN) || (fsm_q == S_SEC);

    unique case (fsm_q)
      S_RUN: begin
        if (btn_mode) begin
          fsm_d  = S_HOUR;
          edit_d = clamp(cur_hour, 6'd24);
        end else if (btn_sw) begin
          fsm_d = S_SW;
        end
      end
      S_SW: begin
        if (btn_sw || btn_mode) fsm_d = S_RUN;
      end
      S_HOUR, S_MIN, S_SEC: begin
        if (btn_mode) begin
          fsm_d = S_RUN;
        end else if (btn_next) begin
          commit = 1'b1;
          unique case (fsm_q)
            S_HOUR: begin
              hour_en_d = 1'b1;
              fsm_d     = S_MIN;
              edit_d    = clamp(cur_min, 6'd60);
            end
            S_MIN: begin
              min_en_d = 1'b1;
              fsm_d    = S_SEC;
              edit_d   = clamp(cur_sec, 6'd60);
            end
            default: begin
              sec_en_d = 1'b1;
              fsm_d    = S_RUN;
            end
          endcase
        end else if (btn_up && !btn_down) begin
          edit_d = (edit_q == lim - 6'd1) ? 6'd0 : edit_q + 6'd1;
        end else if (btn_down && !btn_up) begin
          edit_d = (edit_q == 6'd0) ? lim - 6'd1 : edit_q - 6'd1;
        end else if (!any_btn && cnt_q == TERM) begin
          fsm_d   = S_RUN;
          tflag_d = 1'b1;
        end
      end
      default: fsm_d = S_RUN;
    endcase

    set_d = (fsm_d == S_HOUR) || (fsm_d == S_MIN) || (fsm_d == S_SEC);
    // During a commit cycle num shows the committed value, not the freshly loaded one
    if (commit)     num_d = edit_q;
    else if (set_d) num_d = edit_d;

    if (any_btn || fsm_d != fsm_q) cnt_d = '0;
    else if (set_q)                cnt_d = cnt_q + 1'b1;
    else                           cnt_d = cnt_q;

    unique case (fsm_d)
      S_HOUR:  begin state_d = 2'b01; field_d = 2'b01; end
      S_MIN:   begin state_d = 2'b01; field_d = 2'b10; end
      S_SEC:   begin state_d = 2'b10; field_d = 2'b11; end
      S_SW:    begin state_d = 2'b11; field_d = 2'b00; end
      default: begin state_d = 2'b00; field_d = 2'b00; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q     <= S_RUN;
      edit_q    <= 6'd0;
      num_q     <= 6'd0;
      cnt_q     <= '0;
      state_q   <= 2'b00;
      field_q   <= 2'b00;
      hour_en_q <= 1'b0;
      min_en_q  <= 1'b0;
      sec_en_q  <= 1'b0;
      tflag_q   <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      edit_q    <= edit_d;
      num_q     <= num_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      field_q   <= field_d;
      hour_en_q <= hour_en_d;
      min_en_q  <= min_en_d;
      sec_en_q  <= sec_en_d;
      tflag_q   <= tflag_d;
    end
  end

  assign state        = state_q;
  assign num          = num_q;
  assign hour_enable  = hour_en_q;
  assign min_enable   = min_en_q;
  assign sec_enable   = sec_en_q;
  assign field_sel    = field_q;
  assign timeout_flag = tflag_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_set_controller.sv
// ---------------------------------------------------------------------------
// tb_clock_set_controller : directed + randomized check against a mode/edit model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_clock_set_controller;

  localparam int TO = 10;
  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_MODE = 5'b10000;
  localparam logic [4:0] B_NEXT = 5'b01000;
  localparam logic [4:0] B_UP   = 5'b00100;
  localparam logic [4:0] B_DN   = 5'b00010;
  localparam logic [4:0] B_SW   = 5'b00001;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_next, btn_up, btn_down, btn_sw;
  logic [5:0] cur_hour, cur_min, cur_sec;
  logic [1:0] state;
  logic [5:0] num;
  logic       hour_enable, min_enable, sec_enable;
  logic [1:0] field_sel;
  logic       timeout_flag;

  int n_checks = 0;
  int n_err    = 0;

  // model: mode 0=run 1=hour 2=min 3=sec 4=stopwatch
  int m_mode, m_edit, m_num, m_idle;
  bit e_hen, e_men, e_sen, e_tf;

  clock_set_controller #(
    .TIMEOUT_CYCLES(32'd10),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_mode    (btn_mode),
    .btn_next    (btn_next),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_sw      (btn_sw),
    .cur_hour    (cur_hour),
    .cur_min     (cur_min),
    .cur_sec     (cur_sec),
    .state       (state),
    .num         (num),
    .hour_enable (hour_enable),
    .min_enable  (min_enable),
    .sec_enable  (sec_enable),
    .field_sel   (field_sel),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ld(input int v, input int lim);
    return (v >= lim) ? 0 : v;
  endfunction

  function automatic int exp_state();
    case (m_mode)
      1, 2:    return 1;
      3:       return 2;
      4:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_field();
    return (m_mode >= 1 && m_mode <= 3) ? m_mode : 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_edit = 0; m_num = 0; m_idle = 0;
    e_hen = 0; e_men = 0; e_sen = 0; e_tf = 0;
  endtask

  // b = {mode, next, up, down, sw}
  task automatic model_step(input logic [4:0] b);
    int  prev    = m_mode;
    int  lim     = (m_mode == 1) ? 24 : 60;
    bit  pressed = |b;
    bit  commit  = 0;
    e_hen = 0; e_men = 0; e_sen = 0; e_tf = 0;
    if (m_mode == 0) begin
      if (b[4]) begin
        m_mode = 1;
        m_edit = ld(int'(cur_hour), 24);
      end else if (b[0]) m_mode = 4;
    end else if (m_mode == 4) begin
      if (b[4] || b[0]) m_mode = 0;
    end else begin
      if (b[4]) m_mode = 0;
      else if (b[3]) begin
        commit = 1;
        m_num  = m_edit;
        if (m_mode == 1) begin e_hen = 1; m_edit = ld(int'(cur_min), 60); m_mode = 2; end
        else if (m_mode == 2) begin e_men = 1; m_edit = ld(int'(cur_sec), 60); m_mode = 3; end
        else begin e_sen = 1; m_mode = 0; end
      end else if (b[2] ^ b[1]) begin
        m_edit = b[2] ? (m_edit + 1) % lim : (m_edit + lim - 1) % lim;
      end else if (!pressed && m_idle == TO - 1) begin
        m_mode = 0;
        e_tf   = 1;
      end
    end
    if (!commit && m_mode >= 1 && m_mode <= 3) m_num = m_edit;
    if (pressed || m_mode != prev) m_idle = 0;
    else if (m_mode >= 1 && m_mode <= 3) m_idle++;
  endtask

  task automatic compare_all();
    check("state",     32'(state),        32'(exp_state()));
    check("num",       32'(num),          32'(m_num));
    check("hour_en",   32'(hour_enable),  32'(e_hen));
    check("min_en",    32'(min_enable),   32'(e_men));
    check("sec_en",    32'(sec_enable),   32'(e_sen));
    check("field_sel", 32'(field_sel),    32'(exp_field()));
    check("tflag",     32'(timeout_flag), 32'(e_tf));
  endtask

  task automatic step(input logic [4:0] b);
    {btn_mode, btn_next, btn_up, btn_down, btn_sw} = b;
    model_step(b);
    @(posedge clk);
    #1;
    {btn_mode, btn_next, btn_up, btn_down, btn_sw} = B_NONE;
    compare_all();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int tf_seen, sen_seen;
    logic [4:0] b;
    rst = 1'b0;
    {btn_mode, btn_next, btn_up, btn_down, btn_sw} = B_NONE;
    cur_hour = 6'd0; cur_min = 6'd0; cur_sec = 6'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    compare_all();

    // full set sequence
    cur_hour = 6'd23; cur_min = 6'd5; cur_sec = 6'd17;
    step(B_MODE); check("load_hour", 32'(num), 32'd23);
    step(B_UP);   check("wrap_up", 32'(num), 32'd0);
    step(B_NEXT); check("commit_hour", 32'(hour_enable), 32'd1);
    check("commit_hour_num", 32'(num), 32'd0);
    step(B_NONE); check("hour_en_one_cycle", 32'(hour_enable), 32'd0);
    repeat (6) step(B_DN);
    check("wrap_down", 32'(num), 32'd59);
    step(B_NEXT); check("commit_min_num", 32'(num), 32'd59);
    step(B_NEXT); check("commit_sec_num", 32'(num), 32'd17);
    check("back_to_run", 32'(state), 32'd0);

    // abort from SET_MIN
    cur_hour = 6'd7; cur_min = 6'd30;
    step(B_MODE); step(B_NEXT); step(B_NONE);
    check("edit_30", 32'(num), 32'd30);
    step(B_MODE); check("abort_no_min_en", 32'(min_enable), 32'd0);

    // out-of-range load
    cur_hour = 6'd30;
    step(B_MODE); check("oor_hour", 32'(num), 32'd0);
    step(B_MODE);

    // simultaneous buttons
    cur_hour = 6'd7;
    step(B_MODE); step(B_UP | B_DN);
    check("up_dn_ignored", 32'(num), 32'd7);
    step(B_MODE | B_NEXT);
    check("mode_next_abort", 32'(state), 32'd0);
    step(B_MODE); step(B_NEXT); step(B_NEXT);
    step(B_SW); check("sw_in_set_ignored", 32'(state), 32'd2);

    // idle timeout in SET_SEC
    tf_seen = 0; sen_seen = 0;
    repeat (TO) begin
      step(B_NONE);
      tf_seen  += int'(timeout_flag);
      sen_seen += int'(sec_enable);
    end
    check("timeout_pulses", 32'(tf_seen), 32'd1);
    check("timeout_no_sen", 32'(sen_seen), 32'd0);
    check("timeout_state", 32'(state), 32'd0);

    // button at terminal count discards timeout
    step(B_MODE); step(B_NEXT); step(B_NEXT);
    repeat (TO - 1) step(B_NONE);
    step(B_UP);
    check("no_timeout_state", 32'(state), 32'd2);
    check("no_timeout_flag", 32'(timeout_flag), 32'd0);
    step(B_MODE);

    // stopwatch
    step(B_SW);   check("sw_enter", 32'(state), 32'd3);
    step(B_UP);   step(B_NEXT);
    check("sw_no_strobe", 32'({hour_enable, min_enable, sec_enable}), 32'd0);
    step(B_SW);   check("sw_exit", 32'(state), 32'd0);

    // reset mid-set drops a pending strobe at once
    step(B_MODE); step(B_NEXT);
    #2 rst = 1'b0;
    #1;
    check("async_rst_hen", 32'(hour_enable), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    compare_all();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int r;
      cur_hour = 6'($urandom_range(0, 63));
      cur_min  = 6'($urandom_range(0, 63));
      cur_sec  = 6'($urandom_range(0, 63));
      r = $urandom_range(0, 99);
      if (r < 3) begin
        repeat (TO + 2) step(B_NONE);
      end else begin
        if (r < 55)      b = B_NONE;
        else if (r < 93) b = 5'(5'b00001 << $urandom_range(0, 4));
        else             b = 5'($urandom);
        step(b);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
